// File: rtl/fourphase_rr_arbiter.sv
// Round-robin arbiter that hands one shared four-phase resource to N four-phase requesters.
// The winner's request is relayed to the resource. The resource acknowledge is relayed back to
// the winner. The pointer then moves past the winner so every waiting requester gets a turn.
module fourphase_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         ack,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic                 res_req,
  input  logic                 res_ack,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned W = $clog2(N);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWaitUp = 2'd1;
  localparam logic [1:0] StHold   = 2'd2;
  localparam logic [1:0] StWaitDn = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] owner_q, owner_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic [N-1:0] ack_q, ack_d;
  logic         res_req_q, res_req_d;
  logic         err_q, err_d;

  logic [W-1:0] pick;
  logic         pick_vld;
  logic         own_req;
  logic [W-1:0] owner_inc;

  // Circular search for the first active request at or above the pointer
  always_comb begin
    int unsigned idx;
    idx      = 0;
    pick     = ptr_q;
    pick_vld = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!pick_vld && req[idx]) begin
        pick     = idx[W-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  assign own_req   = req[owner_q];
  assign owner_inc = (32'(owner_q) == N - 1) ? '0 : owner_q + W'(1);

  // Handshake sequencing: grant, relay ack up, wait for release, relay ack down
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    ack_d     = ack_q;
    res_req_d = res_req_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        // res_ack is deliberately not looked at here
        if (pick_vld) begin
          owner_d   = pick;
          gnt_d     = N'(1) << pick;
          res_req_d = 1'b1;
          state_d   = StWaitUp;
        end
      end
      StWaitUp: begin
        // Owner withdrew before its ack: flag it, but still finish the handshake
        if (!own_req) err_d = 1'b1;
        if (res_ack) begin
          ack_d   = N'(1) << owner_q;
          state_d = StHold;
        end
      end
      StHold: begin
        if (!own_req) begin
          res_req_d = 1'b0;
          state_d   = StWaitDn;
        end
      end
      StWaitDn: begin
        if (!res_ack) begin
          ack_d   = '0;
          gnt_d   = '0;
          ptr_d   = owner_inc;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset that aborts any handshake in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      owner_q   <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      res_req_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      res_req_q <= res_req_d;
      err_q     <= err_d;
    end
  end

  assign ack     = ack_q;
  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign res_req = res_req_q;
  assign busy    = (state_q != StIdle);
  assign err     = err_q;

endmodule

// File: tb/tb_fourphase_rr_arbiter.sv
// Bench for fourphase_rr_arbiter. A transaction-level model of the arbiter is advanced on
// every rising edge and compared with all DUT outputs on the falling edge. Directed scenarios
// are followed by a randomized phase with reactive requesters and resource.
module tb_fourphase_rr_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] ack;
  logic [N-1:0] gnt;
  logic [1:0]   owner;
  logic         res_req;
  logic         res_ack;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: a transaction is either absent, or present with acked / released progress flags
  bit m_busy, m_acked, m_released, m_err;
  int m_ptr, m_owner;
  int wait_cnt[N];
  int grant_log[$];

  fourphase_rr_arbiter #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .gnt     (gnt),
    .owner   (owner),
    .res_req (res_req),
    .res_ack (res_ack),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance the model from the inputs sampled on this edge
  task automatic model_update();
    if (rst) begin
      m_busy = 0; m_acked = 0; m_released = 0; m_err = 0;
      m_ptr = 0; m_owner = 0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else if (!m_busy) begin
      bit found = 0;
      for (int k = 0; k < N; k++) begin
        int idx = (m_ptr + k) % N;
        if (!found && req[idx]) begin
          found   = 1;
          m_owner = idx;
        end
      end
      if (found) begin
        m_busy = 1; m_acked = 0; m_released = 0;
        grant_log.push_back(m_owner);
        check("fair", 32'(wait_cnt[m_owner] <= N - 1), 1);
        wait_cnt[m_owner] = 0;
      end
    end else if (!m_acked) begin
      if (!req[m_owner]) m_err = 1;
      if (res_ack) m_acked = 1;
    end else if (!m_released) begin
      if (!req[m_owner]) m_released = 1;
    end else if (!res_ack) begin
      m_busy = 0;
      m_ptr  = (m_owner + 1) % N;
      for (int i = 0; i < N; i++) if (i != m_owner && req[i]) wait_cnt[i]++;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] one;
    one = N'(1) << m_owner;
    check("busy", 32'(busy), 32'(m_busy));
    check("gnt", 32'(gnt), m_busy ? 32'(one) : 0);
    check("ack", 32'(ack), (m_busy && m_acked) ? 32'(one) : 0);
    check("owner", 32'(owner), 32'(m_owner));
    check("res_req", 32'(res_req), 32'(m_busy && !m_released));
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1; req = '0; res_ack = 0;
    step();
    step();
    rst = 0;
  endtask

  // From WAIT_UP: resource acks, requests fall to 'keep', resource releases
  task automatic complete(input logic [N-1:0] keep);
    res_ack = 1; step();
    req = keep;  step();
    res_ack = 0; step();
  endtask

  // Reactive environment; percentages steer the traffic mix
  task automatic env_cycle(input int raise_pct, input int drop_pct, input int resp_pct,
                           input int wd_pct);
    if (res_ack != res_req && $urandom_range(99) < resp_pct) res_ack = res_req;
    for (int i = 0; i < N; i++) begin
      if (!req[i] && !gnt[i]) begin
        if ($urandom_range(99) < raise_pct) req[i] = 1'b1;
      end else if (req[i] && ack[i]) begin
        if ($urandom_range(99) < drop_pct) req[i] = 1'b0;
      end else if (req[i] && gnt[i] && !ack[i]) begin
        if ($urandom_range(999) < wd_pct) req[i] = 1'b0;
      end
    end
  endtask

  initial begin
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    rst = 1; req = '0; res_ack = 0;

    // Single requester: grant, ack relay, release, pointer moves to 1
    do_reset();
    check("rst_gnt", 32'(gnt), 0);
    req = 4'b0001; step();
    check("s_gnt", 32'(gnt), 1);
    step(); step();
    res_ack = 1; step();
    check("s_ack", 32'(ack), 1);
    req = 4'b0000; step();
    res_ack = 0; step();
    check("s_clr", 32'(gnt | ack), 0);
    req = 4'b0011; step();
    check("s_ptr", 32'(owner), 1);
    complete(4'b0000);

    // Contention: all four keep requesting
    do_reset();
    grant_log.delete();
    req = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      step();
      env_cycle(100, 100, 100, 0);
    end
    check("c_len", 32'(grant_log.size() >= 5), 1);
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      check("c_order", 32'(grant_log[k]), 32'(exp_ord[k]));

    // Wrap and skip: ptr=3, req=0101 -> 0 then 2
    do_reset();
    req = 4'b0100; step();
    complete(4'b0000);
    req = 4'b0101; step();
    check("w_first", 32'(owner), 0);
    complete(4'b0100);
    check("w_gap", 32'(busy), 0);
    step();
    check("w_second", 32'(gnt), 4);
    complete(4'b0000);

    // Reset pulsed in HOLD, request held: regranted one edge after release
    do_reset();
    req = 4'b0010; step();
    res_ack = 1; step();
    check("r_hold", 32'(ack), 2);
    rst = 1; step();
    check("r_abort", 32'({gnt, ack, res_req, busy}), 0);
    rst = 0; res_ack = 0; step();
    check("r_regrant", 32'(gnt), 2);
    complete(4'b0000);

    // Withdrawal before ack: sticky err, handshake still completes
    do_reset();
    req = 4'b0001; step();
    req = 4'b0000; step();
    check("wd_err", 32'(err), 1);
    res_ack = 1; step();
    step();
    res_ack = 0; step();
    check("wd_done", 32'(busy), 0);
    step();
    check("wd_sticky", 32'(err), 1);
    rst = 1; step(); rst = 0;
    check("wd_clr", 32'(err), 0);

    // Spurious res_ack while idle
    res_ack = 1;
    for (int c = 0; c < 3; c++) step();
    check("sp_idle", 32'({gnt, ack, res_req, busy}), 0);
    res_ack = 0; step();

    // Randomized traffic with occasional withdrawals and resets
    for (int c = 0; c < 4000; c++) begin
      step();
      env_cycle(25, 50, 40, 20);
      rst = ($urandom_range(299) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
